alarm_ctl: RTL and testbench
============================

# alarm_ctl

Alarm unit downstream of the 12/24-hour clock counters. It holds a user-programmable alarm setpoint (HH:MM, 24-hour BCD) and compares it against the running clock's hour and minute digits. On a match it rings for a bounded time, and it supports snooze. Its setpoint digits and ring status feed the mode/SSD display path. All button inputs arrive already debounced and one-pulsed in the `clk_100` domain.

## Interface
Parameters:
- `RING_SEC`, 30: ticks of `tick_1s` that a ring lasts before auto-off (1..511).
- `SNOOZE_SEC`, 300: ticks of `tick_1s` spent in snooze before re-ringing (1..511).

Ports:
- `clk_100` in 1: the only clock, 100 Hz system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `tick_1s` in 1: one-`clk_100`-cycle strobe, once per second.
- `cur_h1`, `cur_h0`, `cur_m1`, `cur_m0` in 4 each: current time digits, 24-hour BCD.
- `set_mode` in 1: level; 1 = editing the setpoint.
- `arm` in 1: level; 0 = alarm disabled.
- `pb_hr`, `pb_min`, `pb_snooze` in 1 each: one-pulse button strobes.
- `al_h1`, `al_h0`, `al_m1`, `al_m0` out 4 each: setpoint digits, BCD.
- `alarm_on` out 1: state is RINGING.
- `buzz` out 1: buzzer/LED drive.
- `snoozing` out 1: state is SNOOZE.

## Operation
Setpoint:
- Reset value is 00:00.
- `pb_hr` with `set_mode`=1 increments hours; 23 wraps to 00.
- `pb_min` with `set_mode`=1 increments minutes; 59 wraps to 00 with no carry into hours.
- Buttons are ignored when `set_mode`=0. `pb_hr` and `pb_min` in the same cycle both apply.

Match detection:
- `match` = all four current digits equal the setpoint, and `arm`=1, and `set_mode`=0.
- `match_q` registers `match` each cycle. Its reset value is 1, so a 00:00 setpoint does not fire right after reset.
- `trigger` = `match` & !`match_q` (rising edge).

FSM states: IDLE, RINGING, SNOOZE. `cnt` is 9 bits.
- IDLE → RINGING on `trigger`. Clears `cnt`, sets `buzz`=1.
- RINGING:
  - Each `tick_1s` increments `cnt` and toggles `buzz`.
  - When `cnt` reaches `RING_SEC` → IDLE.
  - `pb_snooze` → SNOOZE and clears `cnt`. If `pb_snooze` and the final `tick_1s` arrive in the same cycle, snooze wins.
- SNOOZE:
  - Each `tick_1s` increments `cnt`.
  - When `cnt` reaches `SNOOZE_SEC` → RINGING, clears `cnt`, sets `buzz`=1.
  - `trigger` is ignored.
- Any state → IDLE when `arm`=0 or `set_mode`=1. This has priority over every other transition. `cnt` and `buzz` clear.
- Outputs: `alarm_on` = (state==RINGING). `snoozing` = (state==SNOOZE). `buzz` is 0 outside RINGING.
- Snooze repeats without limit until the alarm is disarmed or the ring auto-expires.

## Timing
- Reset values: state IDLE, `cnt`=0, setpoint 00:00, `match_q`=1, all outputs 0.
- Setpoint outputs update on the clock edge that samples the strobe (1-cycle latency).
- `alarm_on` rises on the edge after the first cycle in which `match` is 1.
- A ring lasts exactly `RING_SEC` `tick_1s` strobes.
- `buzz` toggles on the edges that sample `tick_1s`.
- Asserting `rst` mid-ring clears everything asynchronously. Because `match_q` resets to 1, no re-trigger occurs within the same matching minute.
- All transitions are registered. No output is combinational from inputs.

## Configuration
- `ALARM_SNOOZE_EN`:
  - Defined: the SNOOZE state, the `pb_snooze` handling and `SNOOZE_SEC` are compiled in.
  - Undefined: `pb_snooze` is ignored, SNOOZE is unreachable, `snoozing` is tied to 0, and RINGING exits only by auto-off or disarm.

## Structure
- Package `alarm_pkg`:
  - State enum (IDLE, RINGING, SNOOZE).
  - Constants `HR_MAX`=23, `MIN_MAX`=59, `CNT_W`=9.
- Sub-module `bcd_wrap_counter`: a two-digit BCD incrementer with an enable and a parameterised wrap value. It is instantiated twice, for the hour and minute setpoints.

## Test plan
- Reset, `set_mode`=1, 25 `pb_hr` pulses, 61 `pb_min` pulses → setpoint 01:01, `alarm_on` stays 0.
- Setpoint 07:30, `arm`=1, clock steps 07:29 → 07:30 → `alarm_on`=1 on the next edge. After 30 `tick_1s` strobes `alarm_on`=0; `buzz` toggled 29 times, then 0.
- Ringing, `pb_snooze` after 5 ticks → `snoozing`=1, `buzz`=0. After 300 ticks → `alarm_on`=1, `buzz`=1. Also check `pb_snooze` coinciding with the 30th tick → SNOOZE.
- Ringing, drop `arm` → IDLE next edge, all outputs 0. Re-arm within the same minute → no re-ring (no rising match).
- Setpoint 00:00, assert then release `rst` with clock digits 00:00 → `alarm_on` stays 0 for the whole minute.
- Build without `ALARM_SNOOZE_EN`: ringing plus `pb_snooze` → still RINGING; `snoozing`=0 throughout.

Source files
------------

// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types and constants for the alarm unit
// Contents: FSM state encoding, setpoint wrap values and the ring/snooze
// second-counter width. Imported by alarm_ctl.

package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } alarm_state_t;

    localparam int HR_MAX  = 23;
    localparam int MIN_MAX = 59;
    localparam int CNT_W   = 9;

endpackage

// File: rtl/bcd_wrap_counter.sv
// rtl/bcd_wrap_counter.sv - two-digit BCD incrementer with a wrap value
// Ports:
//   i_clk   clock
//   i_rst   asynchronous active-high reset, clears to 00
//   i_inc   increment enable, one cycle per step
//   o_tens  tens digit, BCD
//   o_ones  ones digit, BCD
// Parameter WRAP: last value before returning to 00 (0..99).

module bcd_wrap_counter #(
    parameter int WRAP = 59
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_inc,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones
);

    localparam logic [3:0] WRAP_T = 4'(WRAP / 10);
    localparam logic [3:0] WRAP_O = 4'(WRAP % 10);

    logic [3:0] r_tens;
    logic [3:0] r_ones;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (i_inc) begin
            if (r_tens == WRAP_T && r_ones == WRAP_O) begin
                r_tens <= 4'd0;
                r_ones <= 4'd0;
            end else if (r_ones == 4'd9) begin
                r_tens <= r_tens + 4'd1;
                r_ones <= 4'd0;
            end else begin
                r_ones <= r_ones + 4'd1;
            end
        end
    end

    assign o_tens = r_tens;
    assign o_ones = r_ones;

endmodule

// File: rtl/alarm_ctl.sv
// rtl/alarm_ctl.sv - alarm setpoint, time match, ring and snooze control
// Optional feature macro: ALARM_SNOOZE_EN (snooze state and pb_snooze).
// Ports:
//   clk_100, rst                 clock; asynchronous active-high reset
//   tick_1s                      one-cycle strobe per second
//   cur_h1/h0/m1/m0              running time, 24-hour BCD
//   set_mode, arm                levels: editing setpoint / alarm enabled
//   pb_hr, pb_min, pb_snooze     one-pulse button strobes
//   al_h1/h0/m1/m0               setpoint digits, BCD
//   alarm_on, buzz, snoozing     ring status, buzzer drive, snooze status

module alarm_ctl
    import alarm_pkg::*;
#(
    parameter int RING_SEC   = 30,
    parameter int SNOOZE_SEC = 300
) (
    input  logic       clk_100,
    input  logic       rst,
    input  logic       tick_1s,
    input  logic [3:0] cur_h1,
    input  logic [3:0] cur_h0,
    input  logic [3:0] cur_m1,
    input  logic [3:0] cur_m0,
    input  logic       set_mode,
    input  logic       arm,
    input  logic       pb_hr,
    input  logic       pb_min,
    input  logic       pb_snooze,
    output logic [3:0] al_h1,
    output logic [3:0] al_h0,
    output logic [3:0] al_m1,
    output logic [3:0] al_m0,
    output logic       alarm_on,
    output logic       buzz,
    output logic       snoozing
);

    localparam logic [CNT_W-1:0] RING_END = CNT_W'(RING_SEC);

    alarm_state_t     r_state;
    alarm_state_t     w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_buzz;
    logic             w_buzz_nxt;
    logic             r_match_q;
    logic             w_match;
    logic             w_trigger;

    bcd_wrap_counter #(.WRAP(HR_MAX)) u_hr (
        .i_clk  (clk_100),
        .i_rst  (rst),
        .i_inc  (set_mode & pb_hr),
        .o_tens (al_h1),
        .o_ones (al_h0)
    );

    bcd_wrap_counter #(.WRAP(MIN_MAX)) u_min (
        .i_clk  (clk_100),
        .i_rst  (rst),
        .i_inc  (set_mode & pb_min),
        .o_tens (al_m1),
        .o_ones (al_m0)
    );

    assign w_match = (cur_h1 == al_h1) && (cur_h0 == al_h0) &&
                     (cur_m1 == al_m1) && (cur_m0 == al_m0) &&
                     arm && !set_mode;

    // Reset to 1 so a setpoint already matching at reset release is not an edge.
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) r_match_q <= 1'b1;
        else     r_match_q <= w_match;
    end

    assign w_trigger = w_match & ~r_match_q;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

`ifdef ALARM_SNOOZE_EN
    localparam logic [CNT_W-1:0] SNOOZE_END = CNT_W'(SNOOZE_SEC);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_buzz_nxt  = r_buzz;
        if (!arm || set_mode) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_buzz_nxt  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        w_state_nxt = RINGING;
                        w_cnt_nxt   = '0;
                        w_buzz_nxt  = 1'b1;
                    end
                end
                RINGING: begin
`ifdef ALARM_SNOOZE_EN
                    // Snooze is checked first so it wins over the final tick.
                    if (pb_snooze) begin
                        w_state_nxt = SNOOZE;
                        w_cnt_nxt   = '0;
                        w_buzz_nxt  = 1'b0;
                    end else
`endif
                    if (tick_1s) begin
                        w_cnt_nxt  = w_cnt_inc;
                        w_buzz_nxt = ~r_buzz;
                        if (w_cnt_inc == RING_END) begin
                            w_state_nxt = IDLE;
                            w_cnt_nxt   = '0;
                            w_buzz_nxt  = 1'b0;
                        end
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (tick_1s) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == SNOOZE_END) begin
                            w_state_nxt = RINGING;
                            w_cnt_nxt   = '0;
                            w_buzz_nxt  = 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_buzz_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_buzz  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_buzz  <= w_buzz_nxt;
        end
    end

    assign alarm_on = (r_state == RINGING);
    assign buzz     = r_buzz;

`ifdef ALARM_SNOOZE_EN
    assign snoozing = (r_state == SNOOZE);
`else
    // Snooze input and period have no effect in this build.
    logic w_unused_snooze;
    assign w_unused_snooze = pb_snooze ^ (SNOOZE_SEC == 0);
    assign snoozing        = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_ctl.sv
// tb/tb_alarm_ctl.sv - directed self-checking bench for alarm_ctl

module tb_alarm_ctl;

    logic       clk_100 = 1'b0;
    logic       rst, tick_1s, set_mode, arm, pb_hr, pb_min, pb_snooze;
    logic [3:0] cur_h1, cur_h0, cur_m1, cur_m0;
    logic [3:0] al_h1, al_h0, al_m1, al_m0;
    logic       alarm_on, buzz, snoozing;
    int         n_cmp = 0;
    int         n_bad = 0;

    alarm_ctl dut (
        .clk_100(clk_100), .rst(rst), .tick_1s(tick_1s),
        .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
        .set_mode(set_mode), .arm(arm),
        .pb_hr(pb_hr), .pb_min(pb_min), .pb_snooze(pb_snooze),
        .al_h1(al_h1), .al_h0(al_h0), .al_m1(al_m1), .al_m0(al_m0),
        .alarm_on(alarm_on), .buzz(buzz), .snoozing(snoozing)
    );

    always #5 clk_100 = ~clk_100;

    task automatic cyc();
        @(posedge clk_100);
        #1;
    endtask

    task automatic set_cur(input logic [15:0] t);
        {cur_h1, cur_h0, cur_m1, cur_m0} = t;
    endtask

    task automatic tick();
        tick_1s = 1'b1;
        cyc();
        tick_1s = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if ({al_h1, al_h0, al_m1, al_m0} !== 16'h0000) begin
            $display("FAIL reset_setpoint: got %h exp 0000", {al_h1, al_h0, al_m1, al_m0}); n_bad++; end
        n_cmp++; if ({alarm_on, buzz, snoozing} !== 3'b000) begin
            $display("FAIL reset_outputs: got %b exp 000", {alarm_on, buzz, snoozing}); n_bad++; end
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_setpoint();
        set_mode = 1'b1;
        for (int i = 0; i < 23; i++) begin
            pb_hr = 1'b1; cyc(); pb_hr = 1'b0;
            if (i == 0) begin
                n_cmp++; if ({al_h1, al_h0} !== 8'h01) begin
                    $display("FAIL hr_latency: got %h exp 01", {al_h1, al_h0}); n_bad++; end
            end
            cyc();
        end
        n_cmp++; if ({al_h1, al_h0} !== 8'h23) begin
            $display("FAIL hr_max: got %h exp 23", {al_h1, al_h0}); n_bad++; end
        repeat (2) begin pb_hr = 1'b1; cyc(); pb_hr = 1'b0; cyc(); end
        n_cmp++; if ({al_h1, al_h0} !== 8'h01) begin
            $display("FAIL hr_wrap: got %h exp 01", {al_h1, al_h0}); n_bad++; end
        repeat (59) begin pb_min = 1'b1; cyc(); pb_min = 1'b0; cyc(); end
        n_cmp++; if ({al_h1, al_h0, al_m1, al_m0} !== 16'h0159) begin
            $display("FAIL min_max: got %h exp 0159", {al_h1, al_h0, al_m1, al_m0}); n_bad++; end
        repeat (2) begin pb_min = 1'b1; cyc(); pb_min = 1'b0; cyc(); end
        n_cmp++; if ({al_h1, al_h0, al_m1, al_m0} !== 16'h0101) begin
            $display("FAIL min_wrap_no_carry: got %h exp 0101", {al_h1, al_h0, al_m1, al_m0}); n_bad++; end
        set_mode = 1'b0;
        pb_hr = 1'b1; pb_min = 1'b1; cyc(); pb_hr = 1'b0; pb_min = 1'b0; cyc();
        n_cmp++; if ({al_h1, al_h0, al_m1, al_m0} !== 16'h0101) begin
            $display("FAIL buttons_ignored: got %h exp 0101", {al_h1, al_h0, al_m1, al_m0}); n_bad++; end
        set_mode = 1'b1;
        repeat (6) begin pb_hr = 1'b1; pb_min = 1'b1; cyc(); pb_hr = 1'b0; pb_min = 1'b0; cyc(); end
        n_cmp++; if ({al_h1, al_h0, al_m1, al_m0} !== 16'h0707) begin
            $display("FAIL both_buttons: got %h exp 0707", {al_h1, al_h0, al_m1, al_m0}); n_bad++; end
        repeat (23) begin pb_min = 1'b1; cyc(); pb_min = 1'b0; cyc(); end
        set_mode = 1'b0;
        cyc();
        n_cmp++; if ({al_h1, al_h0, al_m1, al_m0, alarm_on} !== {16'h0730, 1'b0}) begin
            $display("FAIL setpoint_0730: got %h/%b exp 0730/0", {al_h1, al_h0, al_m1, al_m0}, alarm_on); n_bad++; end
    endtask

    task automatic test_ring();
        int   toggles;
        logic prev;
        arm = 1'b1;
        set_cur(16'h0729);
        repeat (3) cyc();
        n_cmp++; if (alarm_on !== 1'b0) begin
            $display("FAIL pre_match_idle: got %b exp 0", alarm_on); n_bad++; end
        set_cur(16'h0730);
        cyc();
        n_cmp++; if ({alarm_on, buzz} !== 2'b11) begin
            $display("FAIL ring_start: got %b exp 11", {alarm_on, buzz}); n_bad++; end
        toggles = 0;
        prev = buzz;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (buzz !== prev) toggles++;
            prev = buzz;
            if (i == 1) begin
                cyc();
                n_cmp++; if (buzz !== 1'b0) begin
                    $display("FAIL buzz_first_tick: got %b exp 0", buzz); n_bad++; end
            end
            if (i == 29) begin
                n_cmp++; if (alarm_on !== 1'b1) begin
                    $display("FAIL ring_tick29: got %b exp 1", alarm_on); n_bad++; end
            end
        end
        n_cmp++; if ({alarm_on, buzz, toggles} !== {2'b00, 32'd29}) begin
            $display("FAIL ring_auto_off: got on=%b buzz=%b toggles=%0d exp 0/0/29", alarm_on, buzz, toggles); n_bad++; end
        repeat (5) cyc();
        n_cmp++; if (alarm_on !== 1'b0) begin
            $display("FAIL no_retrigger_held: got %b exp 0", alarm_on); n_bad++; end
    endtask

    task automatic test_disarm();
        set_cur(16'h0731); cyc();
        set_cur(16'h0730); cyc();
        n_cmp++; if (alarm_on !== 1'b1) begin
            $display("FAIL disarm_ring_start: got %b exp 1", alarm_on); n_bad++; end
        repeat (3) begin tick(); cyc(); end
        arm = 1'b0;
        cyc();
        n_cmp++; if ({alarm_on, buzz, snoozing} !== 3'b000) begin
            $display("FAIL disarm_idle: got %b exp 000", {alarm_on, buzz, snoozing}); n_bad++; end
        set_cur(16'h0731);
        arm = 1'b1;
        repeat (3) cyc();
        n_cmp++; if (alarm_on !== 1'b0) begin
            $display("FAIL rearm_no_ring: got %b exp 0", alarm_on); n_bad++; end
        set_cur(16'h0730); cyc();
        set_mode = 1'b1; cyc();
        n_cmp++; if ({alarm_on, buzz} !== 2'b00) begin
            $display("FAIL set_mode_abort: got %b exp 00", {alarm_on, buzz}); n_bad++; end
        set_cur(16'h0731);
        set_mode = 1'b0;
        cyc();
    endtask

    task automatic test_reset_midring();
        int hi_cnt;
        set_cur(16'h0730); cyc();
        n_cmp++; if (alarm_on !== 1'b1) begin
            $display("FAIL midring_start: got %b exp 1", alarm_on); n_bad++; end
        repeat (2) begin tick(); cyc(); end
        set_cur(16'h0000);
        rst = 1'b1;
        #2;
        n_cmp++; if ({al_h1, al_h0, al_m1, al_m0, alarm_on, buzz} !== {16'h0000, 2'b00}) begin
            $display("FAIL async_reset: got %h/%b%b exp 0000/00", {al_h1, al_h0, al_m1, al_m0}, alarm_on, buzz); n_bad++; end
        cyc();
        rst = 1'b0;
        hi_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (i % 10 == 0) tick(); else cyc();
            if (alarm_on !== 1'b0) hi_cnt++;
        end
        n_cmp++; if (hi_cnt !== 0) begin
            $display("FAIL midnight_no_fire: got %0d ringing cycles exp 0", hi_cnt); n_bad++; end
    endtask

`ifdef ALARM_SNOOZE_EN
    task automatic test_snooze();
        set_cur(16'h0001); cyc();
        set_cur(16'h0000); cyc();
        repeat (5) begin tick(); cyc(); end
        pb_snooze = 1'b1; cyc(); pb_snooze = 1'b0;
        n_cmp++; if ({alarm_on, buzz, snoozing} !== 3'b001) begin
            $display("FAIL snooze_enter: got %b exp 001", {alarm_on, buzz, snoozing}); n_bad++; end
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 299) begin
                n_cmp++; if ({alarm_on, snoozing} !== 2'b01) begin
                    $display("FAIL snooze_tick299: got %b exp 01", {alarm_on, snoozing}); n_bad++; end
            end
        end
        n_cmp++; if ({alarm_on, buzz, snoozing} !== 3'b110) begin
            $display("FAIL snooze_rering: got %b exp 110", {alarm_on, buzz, snoozing}); n_bad++; end
        repeat (29) tick();
        pb_snooze = 1'b1; tick(); pb_snooze = 1'b0;
        n_cmp++; if ({alarm_on, buzz, snoozing} !== 3'b001) begin
            $display("FAIL snooze_beats_last_tick: got %b exp 001", {alarm_on, buzz, snoozing}); n_bad++; end
        arm = 1'b0; cyc();
        n_cmp++; if ({alarm_on, buzz, snoozing} !== 3'b000) begin
            $display("FAIL snooze_disarm: got %b exp 000", {alarm_on, buzz, snoozing}); n_bad++; end
    endtask
`else
    task automatic test_no_snooze();
        int snz_seen;
        snz_seen = 0;
        set_cur(16'h0001); cyc();
        set_cur(16'h0000); cyc();
        repeat (5) begin tick(); if (snoozing !== 1'b0) snz_seen++; cyc(); end
        pb_snooze = 1'b1; cyc(); pb_snooze = 1'b0;
        if (snoozing !== 1'b0) snz_seen++;
        n_cmp++; if ({alarm_on, buzz} !== 2'b10) begin
            $display("FAIL snooze_ignored: got %b exp 10", {alarm_on, buzz}); n_bad++; end
        repeat (24) begin tick(); if (snoozing !== 1'b0) snz_seen++; end
        pb_snooze = 1'b1; tick(); pb_snooze = 1'b0;
        if (snoozing !== 1'b0) snz_seen++;
        n_cmp++; if ({alarm_on, buzz} !== 2'b00) begin
            $display("FAIL auto_off_with_snooze: got %b exp 00", {alarm_on, buzz}); n_bad++; end
        n_cmp++; if (snz_seen !== 0) begin
            $display("FAIL snoozing_tied_low: got %0d high samples exp 0", snz_seen); n_bad++; end
    endtask
`endif

    initial begin
        rst = 1'b1; tick_1s = 1'b0; set_mode = 1'b0; arm = 1'b0;
        pb_hr = 1'b0; pb_min = 1'b0; pb_snooze = 1'b0;
        set_cur(16'h1234);
        test_reset();
        test_setpoint();
        test_ring();
        test_disarm();
        test_reset_midring();
`ifdef ALARM_SNOOZE_EN
        test_snooze();
`else
        test_no_snooze();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
